// File: rtl/mod_add_ctrl_if.sv
// Request/response and external-adder signal bundle for the modular add/subtract controller.
// The controller sits on the slave modport; the requester plus mpadder environment drives the master side.
`timescale 1ns/1ps
interface mod_add_ctrl_if #(
  parameter int W = 1027
);
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] modulus;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         adder_start;
  logic         adder_subtract;
  logic [W-1:0] adder_in_a;
  logic [W-1:0] adder_in_b;
  logic [W:0]   adder_result;
  logic         adder_done;

  modport slave (
    input  start, subtract, in_a, in_b, modulus, adder_result, adder_done,
    output result, done, busy, adder_start, adder_subtract, adder_in_a, adder_in_b
  );

  modport master (
    output start, subtract, in_a, in_b, modulus, adder_result, adder_done,
    input  result, done, busy, adder_start, adder_subtract, adder_in_a, adder_in_b
  );
endinterface

// File: rtl/mod_add_ctrl.sv
// Modular add/subtract sequencer: drives an external multi-precision adder for one or two
// passes and selects the reduced result, doing no arithmetic itself.
`timescale 1ns/1ps
module mod_add_ctrl #(
  parameter int W = 1027
) (
  input  logic          clk,
  input  logic          reset,
  mod_add_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    FINISH
  } state_t;

  state_t       r_state;
  logic         r_sub;
  logic         r_wait_armed;
  logic [W-1:0] r_m;
  logic [W:0]   r_s;
  logic [W:0]   r_t;
  logic [W-1:0] r_result;
  logic         r_done;
  logic         r_busy;
  logic         r_adder_start;
  logic         r_adder_sub;
  logic [W-1:0] r_adder_a;
  logic [W-1:0] r_adder_b;
  logic [W-1:0] w_final;

  // Add: keep S when S-M went negative. Subtract: S when non-negative, else the S+M correction.
  // NOTE: default assignment first so every path drives w_final and no latch is inferred.
  always_comb begin
    w_final = r_t[W-1:0];
    if (!r_sub) begin
      if (r_t[W]) w_final = r_s[W-1:0];
    end else if (!r_s[W]) begin
      w_final = r_s[W-1:0];
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sub         <= 1'b0;
      r_wait_armed  <= 1'b0;
      r_m           <= '0;
      r_s           <= '0;
      r_t           <= '0;
      r_result      <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_adder_start <= 1'b0;
      r_adder_sub   <= 1'b0;
      r_adder_a     <= '0;
      r_adder_b     <= '0;
    end else begin
      r_done        <= 1'b0;
      r_adder_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sub         <= bus.subtract;
            r_m           <= bus.modulus;
            r_adder_a     <= bus.in_a;
            r_adder_b     <= bus.in_b;
            r_adder_sub   <= bus.subtract;
            r_adder_start <= 1'b1;
            r_busy        <= 1'b1;
            r_state       <= ISSUE1;
          end
        end
        ISSUE1: begin
          r_wait_armed <= 1'b0;
          r_state      <= WAIT1;
        end
        // The first wait cycle may still see adder_done held from the previous operation.
        WAIT1: begin
          if (!r_wait_armed) begin
            r_wait_armed <= 1'b1;
          end else if (bus.adder_done) begin
            r_s <= bus.adder_result;
            if (!r_sub || bus.adder_result[W]) begin
              r_adder_a     <= bus.adder_result[W-1:0];
              r_adder_b     <= r_m;
              r_adder_sub   <= !r_sub;
              r_adder_start <= 1'b1;
              r_state       <= ISSUE2;
            end else begin
              r_state <= FINISH;
            end
          end
        end
        ISSUE2: begin
          r_wait_armed <= 1'b0;
          r_state      <= WAIT2;
        end
        WAIT2: begin
          if (!r_wait_armed) begin
            r_wait_armed <= 1'b1;
          end else if (bus.adder_done) begin
            r_t     <= bus.adder_result;
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_result <= w_final;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result         = r_result;
  assign bus.done           = r_done;
  assign bus.busy           = r_busy;
  assign bus.adder_start    = r_adder_start;
  assign bus.adder_subtract = r_adder_sub;
  assign bus.adder_in_a     = r_adder_a;
  assign bus.adder_in_b     = r_adder_b;

endmodule

// File: tb/tb_mod_add_ctrl.sv
// Bench for mod_add_ctrl: couples it to a variable-latency mpadder model with level-held done,
// and compares every result against (a +/- b) mod M computed with plain wide arithmetic.
`timescale 1ns/1ps
module tb_mod_add_ctrl;
  localparam int W = 1027;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mod_add_ctrl_if #(.W(W)) bus ();
  mod_add_ctrl #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int n_adder_start = 0;
  int n_done = 0;

  // mpadder model: done stays at its old level in the cycle after a command, then
  // drops (with garbage on the result) until the answer is ready.
  int         m_cnt = 0;
  logic [W:0] m_pend = '0;
  logic [W:0] m_res = '0;
  logic       m_done = 1'b0;
  assign bus.adder_result = m_res;
  assign bus.adder_done   = m_done;

  always @(posedge clk) begin
    if (bus.adder_start) begin
      m_pend <= bus.adder_subtract ? ({1'b0, bus.adder_in_a} - {1'b0, bus.adder_in_b})
                                   : ({1'b0, bus.adder_in_a} + {1'b0, bus.adder_in_b});
      m_cnt  <= $urandom_range(1, 4);
      n_adder_start <= n_adder_start + 1;
    end else if (m_cnt > 1) begin
      m_cnt  <= m_cnt - 1;
      m_done <= 1'b0;
      m_res  <= ~m_pend;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_done <= 1'b1;
      m_res  <= m_pend;
    end
  end

  always @(posedge clk) if (bus.done) n_done <= n_done + 1;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m, input logic sub);
    logic [W+1:0] x;
    if (sub) x = ({2'b0, a} + {2'b0, m} - {2'b0, b}) % {2'b0, m};
    else     x = ({2'b0, a} + {2'b0, b}) % {2'b0, m};
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  // Called at a falling edge; start is presented in the current cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic sub, input string tag);
    int           n0 = n_adder_start;
    int           d0;
    int           cmds;
    logic         seen = 1'b0;
    logic [W-1:0] exp = ref_mod(a, b, m, sub);
    cmds = (!sub || a < b) ? 2 : 1;
    bus.start = 1'b1; bus.in_a = a; bus.in_b = b; bus.modulus = m; bus.subtract = sub;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_a = rand_wide(); bus.in_b = rand_wide(); bus.modulus = rand_wide();
    bus.subtract = ~sub;
    d0 = n_done;
    check({tag, "/busy"}, (W+1)'(bus.busy), 1);
    for (int c = 0; c < 100 && !seen; c++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "/done_seen"}, (W+1)'(seen), 1);
    if (seen) begin
      check({tag, "/result"}, {1'b0, bus.result}, {1'b0, exp});
      check({tag, "/busy_at_done"}, (W+1)'(bus.busy), 0);
      check({tag, "/adder_cmds"}, (W+1)'(n_adder_start - n0), (W+1)'(cmds));
      @(negedge clk);
      check({tag, "/done_pulse"}, (W+1)'(bus.done), 0);
      check({tag, "/done_count"}, (W+1)'(n_done - d0), 1);
      check({tag, "/result_held"}, {1'b0, bus.result}, {1'b0, exp});
    end
  endtask

  initial begin
    logic [W-1:0] m13 = W'(13);
    logic [W-1:0] mbig;
    logic [W-1:0] rm;
    logic         seen;
    int           n0;
    int           d0;

    bus.start = 1'b0; bus.subtract = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.modulus = '0;
    mbig = '0;
    mbig[1025] = 1'b1;
    mbig[0] = 1'b1;

    repeat (2) @(negedge clk);
    check("rst/result", {1'b0, bus.result}, 0);
    check("rst/done", (W+1)'(bus.done), 0);
    check("rst/busy", (W+1)'(bus.busy), 0);
    check("rst/adder_start", (W+1)'(bus.adder_start), 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(W'(7), W'(9), m13, 1'b0, "add7+9");
    run_op(W'(3), W'(4), m13, 1'b0, "add3+4");
    run_op(W'(6), W'(7), m13, 1'b0, "add6+7");
    run_op(W'(4), W'(9), m13, 1'b1, "sub4-9");
    run_op(W'(9), W'(4), m13, 1'b1, "sub9-4");
    run_op(W'(5), W'(5), m13, 1'b1, "sub5-5");
    run_op(mbig - 1, mbig - 1, mbig, 1'b0, "big");

    // Abort while waiting on the first adder pass.
    bus.start = 1'b1; bus.in_a = W'(2); bus.in_b = W'(3); bus.modulus = m13; bus.subtract = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort/result", {1'b0, bus.result}, 0);
    check("abort/busy", (W+1)'(bus.busy), 0);
    check("abort/done", (W+1)'(bus.done), 0);
    check("abort/adder_in_a", {1'b0, bus.adder_in_a}, 0);
    check("abort/adder_in_b", {1'b0, bus.adder_in_b}, 0);
    check("abort/adder_sub", (W+1)'(bus.adder_subtract), 0);
    @(negedge clk);
    reset = 1'b0;
    d0 = n_done;
    repeat (10) @(negedge clk);
    check("abort/no_done", (W+1)'(n_done - d0), 0);
    check("abort/result_kept", {1'b0, bus.result}, 0);
    run_op(W'(1), W'(1), m13, 1'b0, "post_abort");

    // Start held high through the whole operation with operands churning.
    n0 = n_adder_start;
    seen = 1'b0;
    bus.start = 1'b1; bus.in_a = W'(7); bus.in_b = W'(9); bus.modulus = m13; bus.subtract = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else begin
        bus.in_a = W'($urandom_range(0, 12));
        bus.in_b = W'($urandom_range(0, 12));
        bus.subtract = 1'($urandom_range(0, 1));
      end
    end
    bus.start = 1'b0;
    check("held/done_seen", (W+1)'(seen), 1);
    check("held/result", {1'b0, bus.result}, 3);
    check("held/adder_cmds", (W+1)'(n_adder_start - n0), 2);
    @(negedge clk);
    check("held/done_pulse", (W+1)'(bus.done), 0);
    run_op(W'(4), W'(9), m13, 1'b1, "held_next");

    for (int i = 0; i < 40; i++) begin
      rm = rand_wide() >> $urandom_range(1, W - 3);
      if (rm == '0) rm = W'(1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(rand_wide() % rm, rand_wide() % rm, rm, 1'($urandom_range(0, 1)),
             $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
